// File: rtl/ip_hdr_sched.sv
// ip_hdr_sched
// Sequencer/arbiter in front of the IP header generator. Grants either the
// transmit path (length/checksum refresh) or the host configuration path
// (set local or destination IP), drives the matching strobe with stable
// operands, waits for the generator's ready pulse (or a timeout), pulses
// the requester's ack, then holds all strobes low for a settle gap.
// Also tracks whether the header buffer holds a valid, checksummed header.
//
// Ports
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_tx_req, i_tx_len    : tx refresh request (level) and length operand
//   o_tx_ack              : one-cycle tx completion pulse
//   i_cfg_req, i_cfg_sel  : cfg request (level); sel 0 = local IP, 1 = dest IP
//   i_cfg_ip              : IP address, [31:24] is the first octet
//   o_cfg_ack             : one-cycle cfg completion pulse
//   o_err                 : pulses with the ack when the operation timed out
//   o_ip_trig/_set_local/_set_dest : level strobes to the generator
//   o_ip_len, o_ip0..o_ip3: operands to the generator (o_ip0 = [31:24])
//   i_ip_ready            : one-cycle done pulse from the generator
//   o_busy                : high whenever not IDLE
//   o_hdr_valid           : header buffer holds a complete, checksummed header
module ip_hdr_sched #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int GAP_CYCLES     = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_tx_req,
   input  logic [15:0] i_tx_len,
   output logic        o_tx_ack,
   input  logic        i_cfg_req,
   input  logic        i_cfg_sel,
   input  logic [31:0] i_cfg_ip,
   output logic        o_cfg_ack,
   output logic        o_err,
   output logic        o_ip_trig,
   output logic        o_ip_set_local,
   output logic        o_ip_set_dest,
   output logic [15:0] o_ip_len,
   output logic [7:0]  o_ip0,
   output logic [7:0]  o_ip1,
   output logic [7:0]  o_ip2,
   output logic [7:0]  o_ip3,
   input  logic        i_ip_ready,
   output logic        o_busy,
   output logic        o_hdr_valid
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [GW-1:0]   gap_cnt, gap_cnt_nx;
   // Set when cfg received the most recent grant; it also identifies the
   // operation in flight, since it is updated on every grant.
   logic            last_cfg, last_cfg_nx;

   logic            tx_ack_nx, cfg_ack_nx, err_nx;
   logic            trig_nx, set_local_nx, set_dest_nx;
   logic [15:0]     len_nx;
   logic [7:0]      ip0_nx, ip1_nx, ip2_nx, ip3_nx;
   logic            busy_nx, hdr_valid_nx;

   // Next-state and next-output computation for the IDLE/WAIT/GAP sequencer.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      gap_cnt_nx   = gap_cnt;
      last_cfg_nx  = last_cfg;
      tx_ack_nx    = 1'b0;
      cfg_ack_nx   = 1'b0;
      err_nx       = 1'b0;
      trig_nx      = o_ip_trig;
      set_local_nx = o_ip_set_local;
      set_dest_nx  = o_ip_set_dest;
      len_nx       = o_ip_len;
      ip0_nx       = o_ip0;
      ip1_nx       = o_ip1;
      ip2_nx       = o_ip2;
      ip3_nx       = o_ip3;
      hdr_valid_nx = o_hdr_valid;

      case (state)
         ST_IDLE: begin
            // tx wins when alone, or on a tie if cfg had the last grant.
            if (i_tx_req && (!i_cfg_req || last_cfg)) begin
               state_nx    = ST_WAIT;
               cnt_nx      = '0;
               last_cfg_nx = 1'b0;
               trig_nx     = 1'b1;
               len_nx      = i_tx_len;
            end else if (i_cfg_req) begin
               state_nx     = ST_WAIT;
               cnt_nx       = '0;
               last_cfg_nx  = 1'b1;
               set_local_nx = ~i_cfg_sel;
               set_dest_nx  = i_cfg_sel;
               ip0_nx       = i_cfg_ip[31:24];
               ip1_nx       = i_cfg_ip[23:16];
               ip2_nx       = i_cfg_ip[15:8];
               ip3_nx       = i_cfg_ip[7:0];
               // A new address invalidates the header until the next refresh.
               hdr_valid_nx = 1'b0;
            end else begin
               state_nx = ST_IDLE;
            end
         end

         ST_WAIT: begin
            // Ready is tested first so it wins over a simultaneous expiry.
            if (i_ip_ready) begin
               state_nx     = ST_GAP;
               gap_cnt_nx   = '0;
               trig_nx      = 1'b0;
               set_local_nx = 1'b0;
               set_dest_nx  = 1'b0;
               tx_ack_nx    = ~last_cfg;
               cfg_ack_nx   = last_cfg;
               hdr_valid_nx = last_cfg ? o_hdr_valid : 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nx     = ST_GAP;
               gap_cnt_nx   = '0;
               trig_nx      = 1'b0;
               set_local_nx = 1'b0;
               set_dest_nx  = 1'b0;
               tx_ack_nx    = ~last_cfg;
               cfg_ack_nx   = last_cfg;
               err_nx       = 1'b1;
               hdr_valid_nx = 1'b0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end

         ST_GAP: begin
            // The ack cycle is the first GAP cycle.
            if (gap_cnt == GAP_LAST) begin
               state_nx = ST_IDLE;
            end else begin
               gap_cnt_nx = gap_cnt + GW'(1);
            end
         end

         default: begin
            state_nx     = ST_IDLE;
            trig_nx      = 1'b0;
            set_local_nx = 1'b0;
            set_dest_nx  = 1'b0;
         end
      endcase

      busy_nx = (state_nx != ST_IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         gap_cnt        <= '0;
         last_cfg       <= 1'b1;
         o_tx_ack       <= 1'b0;
         o_cfg_ack      <= 1'b0;
         o_err          <= 1'b0;
         o_ip_trig      <= 1'b0;
         o_ip_set_local <= 1'b0;
         o_ip_set_dest  <= 1'b0;
         o_ip_len       <= 16'h0000;
         o_ip0          <= 8'h00;
         o_ip1          <= 8'h00;
         o_ip2          <= 8'h00;
         o_ip3          <= 8'h00;
         o_busy         <= 1'b0;
         o_hdr_valid    <= 1'b0;
      end else begin
         state          <= state_nx;
         cnt            <= cnt_nx;
         gap_cnt        <= gap_cnt_nx;
         last_cfg       <= last_cfg_nx;
         o_tx_ack       <= tx_ack_nx;
         o_cfg_ack      <= cfg_ack_nx;
         o_err          <= err_nx;
         o_ip_trig      <= trig_nx;
         o_ip_set_local <= set_local_nx;
         o_ip_set_dest  <= set_dest_nx;
         o_ip_len       <= len_nx;
         o_ip0          <= ip0_nx;
         o_ip1          <= ip1_nx;
         o_ip2          <= ip2_nx;
         o_ip3          <= ip3_nx;
         o_busy         <= busy_nx;
         o_hdr_valid    <= hdr_valid_nx;
      end
   end

endmodule
